imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, instruction-memory word-address width (memory depth 2^ADDR_W words).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-005 SHALL have port: base_addr  input  ADDR_W  first word address, captured on accepted start.
REQ-006 SHALL have port: word_count  input  ADDR_W+1  number of 32-bit words to load, captured on accepted start.
REQ-007 SHALL have port: abort  input  1  cancel an in-progress load.
REQ-008 SHALL have port: in_valid  input  1  byte-stream valid.
REQ-009 SHALL have port: in_data  input  8  byte-stream data.
REQ-010 SHALL have port: in_ready  output  1  byte-stream ready.
REQ-011 SHALL have port: write_en  output  1  one-cycle memory write strobe.
REQ-012 SHALL have port: write_addr  output  ADDR_W  memory word address.
REQ-013 SHALL have port: write_data  output  32  memory write word.
REQ-014 SHALL have port: busy  output  1  high from accepted start until return to IDLE; drives core hold.
REQ-015 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port: err  output  1  sticky error flag; cleared on next accepted start.

Function
REQ-017 SHALL implement the states IDLE, LOAD, CHECK and DONE, with DONE lasting exactly one cycle before returning to IDLE.
REQ-018 SHALL, in IDLE, capture base_addr and word_count on start=1 and enter LOAD next cycle; with word_count=0 it SHALL enter DONE directly (CHECK instead when REQ-029 applies) and issue no writes.
REQ-019 SHALL drive in_ready=1 only in LOAD and CHECK, and SHALL accept a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-020 SHALL assemble bytes little-endian: byte 0 -> bits 7:0, byte 3 -> bits 31:24.
REQ-021 SHALL, on the cycle after the 4th byte of a word is accepted, assert write_en for exactly one cycle with registered write_addr and write_data.
REQ-022 SHALL compute write_addr = (base_addr + word_index) mod 2^ADDR_W, wrapping from 2^ADDR_W-1 to 0.
REQ-023 SHALL, after the write of word word_count-1, enter DONE (CHECK when REQ-029 applies); in_ready SHALL drop in the same cycle the final byte is accepted.
REQ-024 SHALL treat word_count greater than 2^ADDR_W as a full 2^ADDR_W words.
REQ-025 SHALL, when abort=1 in LOAD or CHECK, return to IDLE next cycle, discard any partial word, set err=1 and not pulse done; a full word whose write is pending SHALL still be written.
REQ-026 SHALL ignore start outside IDLE; abort SHALL take priority over byte acceptance in the same cycle.
REQ-027 SHALL hold write_addr and write_data stable while write_en=0.

Reset
REQ-028 SHALL, when rst=0, asynchronously force IDLE and set in_ready, write_en, write_addr, write_data, busy, done, err, the byte counter, the word counter and the checksum all to 0; reset mid-load SHALL abandon the load without a done pulse.

Configuration
REQ-029 SHALL, with macro IMEM_LOADER_CHECKSUM_EN defined, require one extra byte in CHECK after the last word; err=1 SHALL be set if the 8-bit sum of all data bytes plus the checksum byte is not 0 mod 256; done SHALL pulse in both cases.
REQ-030 SHALL, without IMEM_LOADER_CHECKSUM_EN, omit CHECK and the checksum logic, go from the last write straight to DONE, and let err be set only by abort.

Verification
REQ-031 SHALL cover: base_addr=0x010, word_count=2, bytes 78 56 34 12 EF BE AD DE -> write_en pulses with (0x010, 0x12345678) and (0x011, 0xDEADBEEF); done one cycle after (after the checksum byte when REQ-029 applies); busy high throughout.
REQ-032 SHALL cover: base_addr=0x3FF, word_count=2 -> writes to 0x3FF then 0x000.
REQ-033 SHALL cover: in_valid toggled randomly with 1-3 idle cycles between bytes -> identical write sequence, no lost or duplicated bytes.
REQ-034 SHALL cover: abort after 6 bytes of a 3-word load -> exactly one write, IDLE next cycle, err=1, no done; then a new start clears err.
REQ-035 SHALL cover: with IMEM_LOADER_CHECKSUM_EN, 1 word 01 02 03 04 plus checksum 0xF6 -> err=0, and plus checksum 0xF7 -> err=1.
REQ-036 SHALL cover: rst asserted low mid-word -> all outputs 0 immediately, no write_en, and the following load behaves as in REQ-031.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a little-endian byte stream and writes it as 32-bit
// words into instruction memory, starting at a captured base address.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte after the last word (8-bit sum of all bytes must be zero).
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  // State entered once all words have been written.
  localparam state_t ST_TAIL = ST_CHECK;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd3
  } state_t;
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W:0]   r_words_total;
  logic [ADDR_W-1:0] r_addr;
  logic [23:0]       r_partial;
  logic              r_last;
  logic              r_write_en;
  logic [ADDR_W-1:0] r_write_addr;
  logic [31:0]       r_write_data;
  logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
  logic [7:0]        w_sum_total;
`endif

  logic [ADDR_W:0]   w_count_eff;
  logic [ADDR_W:0]   w_word_cnt_inc;
  logic              w_active;
  logic              w_accept;
  logic              w_load_byte;

  // Requests above the memory depth are clamped to a full-memory load.
  assign w_count_eff    = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign w_word_cnt_inc = r_word_cnt + ONE_WORD;
  // Abort wins over byte acceptance in the same cycle.
  assign w_accept       = in_valid && in_ready && !abort;
  assign w_load_byte    = w_accept && (r_state == ST_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign w_sum_total    = r_sum + in_data;
`endif

  assign write_en   = r_write_en;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;
  assign err        = r_err;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (w_count_eff == '0) ? ST_TAIL : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // r_last marks the cycle in which the final word's write is issued.
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (r_last) begin
          w_state_next = ST_TAIL;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_accept) begin
          w_state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    w_active = (r_state == ST_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (r_state == ST_CHECK) begin
      w_active = 1'b1;
    end
`endif
    // Ready drops right after the last data byte so no extra byte is taken.
    in_ready = w_active && !((r_state == ST_LOAD) && r_last);
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE);
  end

  // Byte assembly, word writes, counters and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt    <= '0;
      r_word_cnt    <= '0;
      r_words_total <= '0;
      r_addr        <= '0;
      r_partial     <= '0;
      r_last        <= 1'b0;
      r_write_en    <= 1'b0;
      r_write_addr  <= '0;
      r_write_data  <= '0;
      r_err         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum         <= '0;
`endif
    end else begin
      r_write_en <= 1'b0;
      if ((r_state == ST_IDLE) && start) begin
        r_addr        <= base_addr;
        r_words_total <= w_count_eff;
        r_word_cnt    <= '0;
        r_byte_cnt    <= '0;
        r_partial     <= '0;
        r_last        <= 1'b0;
        r_err         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum         <= '0;
`endif
      end else if (abort && w_active) begin
        // Partial word is dropped; an already-registered write still fires.
        r_err      <= 1'b1;
        r_byte_cnt <= '0;
        r_partial  <= '0;
      end else if (w_load_byte) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum      <= w_sum_total;
`endif
        case (r_byte_cnt)
          2'd0: r_partial[7:0]   <= in_data;
          2'd1: r_partial[15:8]  <= in_data;
          2'd2: r_partial[23:16] <= in_data;
          default: begin
            r_write_en   <= 1'b1;
            r_write_addr <= r_addr;
            r_write_data <= {in_data, r_partial};
            r_addr       <= r_addr + ONE_ADDR;
            r_word_cnt   <= w_word_cnt_inc;
            if (w_word_cnt_inc == r_words_total) begin
              r_last <= 1'b1;
            end
          end
        endcase
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      else if (w_accept && (r_state == ST_CHECK)) begin
        if (w_sum_total != 8'd0) begin
          r_err <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven loads, randomized loads checked
// against a word-level reference model, and hand-written timing sequences.
// Build with IMEM_LOADER_CHECKSUM_EN defined to exercise the checksum path.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        write_en;
  logic [9:0]  write_addr;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int stab_viol = 0;
  logic [9:0]  got_a[$];
  logic [31:0] got_d[$];
  logic [7:0]  fix_q[$];
  logic [9:0]  prev_a = '0;
  logic [31:0] prev_d = '0;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] cnt;
    bit          gaps;
    int          abort_after;
    bit          ck_good;
    int          exp_w;
    bit          exp_done;
    bit          exp_err_nock;
    bit          exp_err_ck;
  } vec_t;
  vec_t tbl[8];

  // Write/done monitor plus hold-stability tracking on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (write_en) begin
        got_a.push_back(write_addr);
        got_d.push_back(write_data);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (!write_en && (write_addr !== prev_a || write_data !== prev_d))
        stab_viol <= stab_viol + 1;
    end
    prev_a <= write_addr;
    prev_d <= write_data;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    ok = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_start(input string nm, input logic [9:0] base, input logic [10:0] cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = 10'($urandom);
    word_count = 11'($urandom);
    @(negedge clk);
    chk({nm, "_err_cleared"}, 64'(err), 64'(0));
    chk({nm, "_busy_after_start"}, 64'(busy), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Generic load: the model computes expected writes from the byte list.
  task automatic run_load(input string nm, input logic [9:0] base, input logic [10:0] cnt,
                          input bit gaps, input int abort_after, input bit ck_good,
                          input bit rand_bytes, input int exp_w, input bit exp_done,
                          input bit exp_err);
    int nw, nsend, d0, f0, n;
    bit ok;
    logic [7:0]  bq[$];
    logic [9:0]  ea[$];
    logic [31:0] ed[$];
    logic [7:0]  sum;
    logic [7:0]  ckb;
    nw = (cnt > 11'd1024) ? 1024 : int'(cnt);
    if (rand_bytes) begin
      for (int i = 0; i < 4 * nw; i++) bq.push_back(8'($urandom));
    end else begin
      bq = fix_q;
    end
    nsend = (abort_after >= 0) ? abort_after : 4 * nw;
    for (int i = 0; i < nsend / 4; i++) begin
      ea.push_back(10'((int'(base) + i) % 1024));
      ed.push_back(32'(bq[4*i]) + (32'(bq[4*i+1]) * 256) +
                   (32'(bq[4*i+2]) * 65536) + (32'(bq[4*i+3]) * 16777216));
    end
    sum = 8'd0;
    foreach (bq[i]) sum = sum + bq[i];
    ckb = 8'd0 - sum;
    if (!ck_good) ckb = ckb + 8'd1;

    got_a = {};
    got_d = {};
    d0 = done_cnt;
    do_start(nm, base, cnt);
    for (int i = 0; i < nsend; i++) begin
      send_byte(bq[i], gaps, ok);
      if (!ok) begin
        chk({nm, "_byte_timeout"}, 64'(ok), 64'(1));
        break;
      end
    end
    if (abort_after >= 0) begin
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk({nm, "_idle_after_abort"}, 64'(busy), 64'(0));
      chk({nm, "_ready_after_abort"}, 64'(in_ready), 64'(0));
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(ckb, gaps, ok);
      if (!ok) chk({nm, "_ck_timeout"}, 64'(ok), 64'(1));
`endif
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (!busy) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk({nm, "_idle_timeout"}, 64'(busy), 64'(0));
    end
    chk({nm, "_nwrites"}, 64'(got_a.size()), 64'(exp_w));
    n = (got_a.size() < ea.size()) ? got_a.size() : ea.size();
    f0 = failures;
    for (int i = 0; i < n; i++) begin
      chk({nm, "_write"}, 64'({got_a[i], got_d[i]}), 64'({ea[i], ed[i]}));
      if (failures != f0) break;
    end
    chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'(exp_done));
    chk({nm, "_err"}, 64'(err), 64'(exp_err));
    @(posedge clk);
    #1;
  endtask

  // Two-word load with cycle-exact checks around the final write and done.
  task automatic run_basic(input string nm);
    logic [7:0] b[8];
    bit ok;
    int d0;
    b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    got_a = {};
    got_d = {};
    d0 = done_cnt;
    do_start(nm, 10'h010, 11'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(b[i], 1'b0, ok);
      if (!ok) chk({nm, "_byte_timeout"}, 64'(ok), 64'(1));
      if (i == 3) begin
        start      = 1'b1;
        base_addr  = 10'h155;
        word_count = 11'd1;
      end
      if (i == 4) start = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_last_we"}, 64'(write_en), 64'(1));
    chk({nm, "_last_addr"}, 64'(write_addr), 64'(10'h011));
    chk({nm, "_last_data"}, 64'(write_data), 64'(32'hDEADBEEF));
    chk({nm, "_ready_dropped"}, 64'(in_ready), 64'(0));
    chk({nm, "_busy_during"}, 64'(busy), 64'(1));
    chk({nm, "_no_early_done"}, 64'(done), 64'(0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(posedge clk);
    #1;
    send_byte(8'hB4, 1'b0, ok);
    if (!ok) chk({nm, "_ck_timeout"}, 64'(ok), 64'(1));
    @(negedge clk);
    chk({nm, "_done"}, 64'(done), 64'(1));
    chk({nm, "_err"}, 64'(err), 64'(0));
`else
    @(negedge clk);
    chk({nm, "_done"}, 64'(done), 64'(1));
    chk({nm, "_we_single"}, 64'(write_en), 64'(0));
    chk({nm, "_busy_in_done"}, 64'(busy), 64'(1));
`endif
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, 64'(done), 64'(0));
    chk({nm, "_idle"}, 64'(busy), 64'(0));
    chk({nm, "_nwrites"}, 64'(got_a.size()), 64'(2));
    chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    if (got_a.size() == 2) begin
      chk({nm, "_w0"}, 64'({got_a[0], got_d[0]}), 64'({10'h010, 32'h12345678}));
      chk({nm, "_w1"}, 64'({got_a[1], got_d[1]}), 64'({10'h011, 32'hDEADBEEF}));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int c, ab, d0;
    bit g, ckg, ee;
    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0;

    //            base    cnt      gaps abort ckgood w     done errN errC
    tbl[0] = '{10'h3FF, 11'd2,    1'b0, -1, 1'b1, 2,    1'b1, 1'b0, 1'b0};
    tbl[1] = '{10'h010, 11'd2,    1'b1, -1, 1'b1, 2,    1'b1, 1'b0, 1'b0};
    tbl[2] = '{10'h005, 11'd3,    1'b0,  6, 1'b1, 1,    1'b0, 1'b1, 1'b1};
    tbl[3] = '{10'h020, 11'd1,    1'b0, -1, 1'b0, 1,    1'b1, 1'b0, 1'b1};
    tbl[4] = '{10'h100, 11'd0,    1'b0, -1, 1'b1, 0,    1'b1, 1'b0, 1'b0};
    tbl[5] = '{10'h0AB, 11'd4,    1'b1, -1, 1'b1, 4,    1'b1, 1'b0, 1'b0};
    tbl[6] = '{10'h07F, 11'd3,    1'b1,  8, 1'b1, 2,    1'b0, 1'b1, 1'b1};
    tbl[7] = '{10'h200, 11'd2047, 1'b0, -1, 1'b1, 1024, 1'b1, 1'b0, 1'b0};

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_write_en", 64'(write_en), 64'(0));
    chk("rst_write_addr", 64'(write_addr), 64'(0));
    chk("rst_write_data", 64'(write_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_basic("basic");

    for (int i = 0; i < 8; i++) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      ee = tbl[i].exp_err_ck;
`else
      ee = tbl[i].exp_err_nock;
`endif
      run_load($sformatf("tbl%0d", i), tbl[i].base, tbl[i].cnt, tbl[i].gaps,
               tbl[i].abort_after, tbl[i].ck_good, 1'b1, tbl[i].exp_w,
               tbl[i].exp_done, ee);
    end

    for (int k = 0; k < 6; k++) begin
      c   = int'($urandom_range(1, 5));
      g   = 1'($urandom_range(0, 1));
      ckg = 1'($urandom_range(0, 1));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * c - 1)) : -1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ee = (ab >= 0) || !ckg;
`else
      ee = (ab >= 0);
`endif
      run_load($sformatf("rnd%0d", k), 10'($urandom), 11'(c), g, ab, ckg, 1'b1,
               (ab >= 0) ? ab / 4 : c, (ab < 0), ee);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    fix_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load("ck_f6", 10'h040, 11'd1, 1'b0, -1, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    run_load("ck_f7", 10'h040, 11'd1, 1'b0, -1, 1'b0, 1'b0, 1, 1'b1, 1'b1);
`endif

    // Reset asserted in the middle of a word.
    got_a = {};
    got_d = {};
    d0 = done_cnt;
    do_start("rstmid", 10'h010, 11'd2);
    send_byte(8'h78, 1'b0, ok);
    send_byte(8'h56, 1'b0, ok);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_in_ready", 64'(in_ready), 64'(0));
    chk("rstmid_write_en", 64'(write_en), 64'(0));
    chk("rstmid_write_addr", 64'(write_addr), 64'(0));
    chk("rstmid_write_data", 64'(write_data), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_done", 64'(done), 64'(0));
    chk("rstmid_err", 64'(err), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_no_write", 64'(got_a.size()), 64'(0));
    chk("rstmid_no_done", 64'(done_cnt - d0), 64'(0));
    chk("rstmid_idle", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    run_basic("post_reset");

    chk("hold_stability_violations", 64'(stab_viol), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
